// File: rtl/fma_pkg.sv
// Shared types and constants for the fma normalize/round/pack stage.
package fma_pkg;

    localparam int FMA_MAN_W = 48;
    localparam int FMA_EXP_W = 10;
    localparam int BIAS      = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF  = 32'h7F80_0000;
    localparam logic [31:0] MAXF = 32'h7F7F_FFFF;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'b00,
        CLS_ZERO   = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } fma_class_e;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } fma_rmode_e;

endpackage

// File: rtl/fma_lzc.sv
// Combinational leading-zero counter; o_zero flags an all-zero input.
module fma_lzc #(
    parameter int W  = 48,
    parameter int CW = $clog2(W)
) (
    input  logic [W-1:0]  i_data,
    output logic [CW-1:0] o_count,
    output logic          o_zero
);

    always_comb begin
        o_count = '0;
        // Scanning upward lets the highest set bit win.
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) o_count = CW'(W - 1 - i);
        end
        o_zero = (i_data == '0);
    end

endmodule

// File: rtl/fma_round.sv
// fma_round: normalize, round and pack the fma core's raw sum into binary32 plus flags.
// Define FMA_RMODE_EN to add the rm port (RNE/RTZ/RDN/RUP); otherwise RNE only.
module fma_round
    import fma_pkg::*;
#(
    parameter int MAN_W = FMA_MAN_W,
    parameter int EXP_W = FMA_EXP_W
) (
`ifdef FMA_RMODE_EN
    input  logic [1:0]       rm,
`endif
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W-1:0] in_man,
    input  logic             in_sticky,
    input  logic [1:0]       in_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [2:0]       out_flags
);

    localparam int EW    = 12;
    localparam int LZ_W  = $clog2(MAN_W);
    localparam int G_POS = MAN_W - 25;
    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_CAP  = EW'(26);
    localparam logic signed [EW-1:0] E_OVF  = EW'(2 * BIAS + 1);

    logic                    r_s1_valid, r_s2_valid;
    logic                    w_s2_adv, w_s1_load;
    logic [LZ_W-1:0]         w_lz;
    logic                    w_zero, w_tiny;
    logic signed [EW-1:0]    w_exp_ext, w_e, w_rsh_full;
    logic [4:0]              w_rsh;
    logic [MAN_W-1:0]        w_norm, w_den, w_lost;

    logic [23:0]             r_s1_frac;
    logic                    r_s1_g, r_s1_s, r_s1_tiny, r_s1_sign, r_s1_zero;
    logic signed [EW-1:0]    r_s1_e;
    logic [1:0]              r_s1_class;
    fma_rmode_e              w_rm;

    logic                    w_inc, w_inx, w_ovf, w_tz;
    logic [24:0]             w_rnd;
    logic signed [EW-1:0]    w_exp_rnd;
    logic [31:0]             w_res, r_result;
    logic [2:0]              w_flg, r_flags;

    assign w_s2_adv  = !r_s2_valid | out_ready;
    assign in_ready  = !r_s1_valid | w_s2_adv;
    assign w_s1_load = in_valid & in_ready;

    // ---- S1: normalize the leading one to the top bit, denormalize when tiny ----
    fma_lzc #(.W(MAN_W), .CW(LZ_W)) u_lzc (
        .i_data  (in_man),
        .o_count (w_lz),
        .o_zero  (w_zero)
    );

    assign w_exp_ext  = {{(EW-EXP_W){in_exp[EXP_W-1]}}, in_exp};
    assign w_e        = w_exp_ext + E_ONE - $signed({{(EW-LZ_W){1'b0}}, w_lz});
    assign w_tiny     = (w_e <= E_ZERO);
    assign w_rsh_full = E_ONE - w_e;
    // Beyond 26 places everything is already below the guard bit.
    assign w_rsh      = !w_tiny ? 5'd0 : (w_rsh_full > E_CAP) ? 5'd26 : w_rsh_full[4:0];
    assign w_norm     = in_man << w_lz;
    assign w_den      = w_norm >> w_rsh;
    assign w_lost     = w_norm & ~({MAN_W{1'b1}} << w_rsh);

`ifdef FMA_RMODE_EN
    logic [1:0] r_s1_rm;
    always_ff @(posedge clk) begin
        if (w_s1_load) r_s1_rm <= rm;
    end
    assign w_rm = fma_rmode_e'(r_s1_rm);
`else
    assign w_rm = RM_RNE;
`endif

    always_ff @(posedge clk) begin
        if (w_s1_load) begin
            r_s1_frac  <= w_den[MAN_W-1 -: 24];
            r_s1_g     <= w_den[G_POS];
            r_s1_s     <= (|w_den[G_POS-1:0]) | (|w_lost) | in_sticky;
            r_s1_e     <= w_e;
            r_s1_tiny  <= w_tiny;
            r_s1_sign  <= in_sign;
            r_s1_zero  <= w_zero;
            r_s1_class <= in_class;
        end
    end

    // ---- S2: round, detect overflow, pack and select specials ----
    always_comb begin
        w_inc = 1'b0;
        case (w_rm)
            RM_RNE: w_inc = r_s1_g & (r_s1_frac[0] | r_s1_s);
            RM_RTZ: w_inc = 1'b0;
            RM_RDN: w_inc = (r_s1_g | r_s1_s) & r_s1_sign;
            RM_RUP: w_inc = (r_s1_g | r_s1_s) & ~r_s1_sign;
            default: w_inc = 1'b0;
        endcase
    end

    assign w_inx     = r_s1_g | r_s1_s;
    assign w_rnd     = {1'b0, r_s1_frac} + {24'b0, w_inc};
    // A subnormal that carries into bit 23 has become the smallest normal.
    assign w_exp_rnd = r_s1_tiny ? $signed({{(EW-1){1'b0}}, w_rnd[23]})
                                 : r_s1_e + $signed({{(EW-1){1'b0}}, w_rnd[24]});
    assign w_ovf     = !r_s1_tiny && (w_exp_rnd >= E_OVF);
    assign w_tz      = (w_rm == RM_RTZ) | ((w_rm == RM_RDN) & ~r_s1_sign)
                     | ((w_rm == RM_RUP) & r_s1_sign);

    always_comb begin
        w_res = {r_s1_sign, w_exp_rnd[7:0], w_rnd[22:0]};
        w_flg = {1'b0, r_s1_tiny & w_inx, w_inx};
        if (r_s1_class == CLS_NAN) begin
            w_res = QNAN;
            w_flg = 3'b000;
        end else if (r_s1_class == CLS_INF) begin
            w_res = INF | {r_s1_sign, 31'b0};
            w_flg = 3'b000;
        end else if (r_s1_class == CLS_ZERO) begin
            w_res = {r_s1_sign, 31'b0};
            w_flg = 3'b000;
        end else if (r_s1_zero) begin
            w_res = {(w_rm == RM_RDN), 31'b0};
            w_flg = 3'b000;
        end else if (w_ovf) begin
            w_res = (w_tz ? MAXF : INF) | {r_s1_sign, 31'b0};
            w_flg = 3'b101;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else begin
            if (in_ready) r_s1_valid <= in_valid;
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_result <= w_res;
                    r_flags  <= w_flg;
                end
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_result;
    assign out_flags  = r_flags;

endmodule
